// File: rtl/axis_demux.sv
// Purpose: AXI-Stream packet demux; routes whole packets to one of NUM_SINKS sinks by the tuser dest field of the head beat, drops and counts bad dests.
// Latency: one registered output stage, beat accepted at cycle N is presented at N+1, full throughput back-to-back.
// Backpressure: s_tready = !held || selected sink ready (all sinks for broadcast); always ready while dropping. Optional AXIS_DEMUX_BROADCAST_EN.
module axis_demux #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 8,
  parameter int NUM_SINKS  = 2,
  parameter int DEST_LSB   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic [USER_WIDTH-1:0] s_tuser,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  output logic [NUM_SINKS-1:0]  m_tvalid,
  input  logic [NUM_SINKS-1:0]  m_tready,
  output logic                  m_tlast,
  output logic [USER_WIDTH-1:0] m_tuser,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  drop_pulse,
  output logic [15:0]           drop_count
);

  localparam int DEST_W = $clog2(NUM_SINKS + 1);
  localparam logic [DEST_W-1:0] NUM_SINKS_CODE = DEST_W'(NUM_SINKS);
  localparam logic [DEST_W-1:0] BCAST_CODE = '1;

  typedef enum logic [1:0] {HEAD, FWD, DROP} state_t;

  state_t state, stateNext;

  // Latched destination of the packet currently being forwarded.
  logic [DEST_W-1:0] pktDest;
  logic              pktBcast;

  // Single-entry output register; destination travels with the beat.
  logic                  outValid;
  logic [DEST_W-1:0]     outDest;
  logic                  outBcast;
  logic [DATA_WIDTH-1:0] outData;
  logic [USER_WIDTH-1:0] outUser;
  logic                  outLast;

  logic [DEST_W-1:0] headDest;
  logic              headValid;
  logic              headBcast;
  logic              selReady;
  logic              outLeave;
  logic              sReady;
  logic              accept;
  logic              load;
  logic [DEST_W-1:0] loadDest;
  logic              loadBcast;
  logic              dropEvent;

  assign headDest = s_tuser[DEST_LSB +: DEST_W];

  // Classify the destination code carried on a would-be head beat.
  always_comb begin
    headBcast = 1'b0;
`ifdef AXIS_DEMUX_BROADCAST_EN
    headBcast = (headDest == BCAST_CODE);
`endif
    headValid = (headDest < NUM_SINKS_CODE) || headBcast;
  end

  // Decide whether the held beat drains this cycle (only its own sink's ready matters).
  always_comb begin
    selReady = 1'b0;
    for (int k = 0; k < NUM_SINKS; k++) begin
      if (outDest == DEST_W'(k)) selReady = m_tready[k];
    end
    outLeave = outValid && (outBcast ? (&m_tready) : selReady);
  end

  // Next-state, input handshake and load/drop decisions.
  always_comb begin
    stateNext = state;
    sReady    = !outValid || outLeave;
    if (state == DROP) sReady = 1'b1;
    accept    = s_tvalid && sReady;
    load      = 1'b0;
    loadDest  = pktDest;
    loadBcast = pktBcast;
    dropEvent = 1'b0;
    case (state)
      HEAD: begin
        if (accept) begin
          if (headValid) begin
            load      = 1'b1;
            loadDest  = headDest;
            loadBcast = headBcast;
            stateNext = s_tlast ? HEAD : FWD;
          end else if (s_tlast) begin
            dropEvent = 1'b1;
          end else begin
            stateNext = DROP;
          end
        end
      end
      FWD: begin
        if (accept) begin
          load = 1'b1;
          if (s_tlast) stateNext = HEAD;
        end
      end
      DROP: begin
        if (accept && s_tlast) begin
          dropEvent = 1'b1;
          stateNext = HEAD;
        end
      end
      default: stateNext = HEAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= HEAD;
    else     state <= stateNext;
  end

  // Packet routing context, refreshed on every forwarded beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      pktDest  <= '0;
      pktBcast <= 1'b0;
    end else if (load) begin
      pktDest  <= loadDest;
      pktBcast <= loadBcast;
    end
  end

  // Output register: load wins over drain so a new beat can replace a leaving one.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid <= 1'b0;
      outDest  <= '0;
      outBcast <= 1'b0;
      outData  <= '0;
      outUser  <= '0;
      outLast  <= 1'b0;
    end else if (load) begin
      outValid <= 1'b1;
      outDest  <= loadDest;
      outBcast <= loadBcast;
      outData  <= s_tdata;
      outUser  <= s_tuser;
      outLast  <= s_tlast;
    end else if (outLeave) begin
      outValid <= 1'b0;
    end
  end

  // Drop pulse and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_pulse <= 1'b0;
      drop_count <= '0;
    end else begin
      drop_pulse <= dropEvent;
      if (dropEvent && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end

  // Per-sink valid decode of the held beat.
  always_comb begin
    m_tvalid = '0;
    for (int k = 0; k < NUM_SINKS; k++) begin
      m_tvalid[k] = outValid && (outBcast || (outDest == DEST_W'(k)));
    end
  end

  assign s_tready = sReady;
  assign m_tdata  = outData;
  assign m_tuser  = outUser;
  assign m_tlast  = outLast;

endmodule
